sp_issue_ctrl: RTL and testbench
================================

Name: sp_issue_ctrl

Overview:
- Instruction-issue sequencer for the single-cycle processor core (SP): fetches each instruction from a synchronous instruction ROM at the core's current inst_addr, drives the core's in_valid/inst handshake, and waits for out_valid.
- Enforces a completion-latency limit, counts retired instructions and stops after a programmed count.
- Replaces the testbench-driven issue loop so the core can be run stand-alone on FPGA or in system simulation.

Parameters:
- ROM_AW, 10, instruction ROM word-address width (1024 words)
- MAX_LAT, 10, WAIT cycles without out_valid before timeout
- CNT_W, 16, width of instruction count and num_inst

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  pulse, begins a run; honored only in IDLE
- abort  in  1  synchronous; forces IDLE from any state next cycle
- num_inst  in  CNT_W  instructions to retire; sampled at start
- rom_en  out  1  ROM read enable
- rom_addr  out  ROM_AW  ROM word address
- rom_rdata  in  32  ROM data, valid the cycle after rom_en
- sp_in_valid  out  1  to core in_valid
- sp_inst  out  32  to core inst
- sp_out_valid  in  1  from core out_valid
- sp_inst_addr  in  32  from core inst_addr (byte PC)
- busy  out  1  high in any state except IDLE, DONE and ERR
- done  out  1  one-cycle pulse when num_inst retired
- err  out  1  sticky error flag, cleared by start
- err_code  out  2  0 none, 1 timeout, 2 PC out of ROM range, 3 misaligned PC
- inst_count  out  CNT_W  instructions retired this run

Behaviour:
- Reset (async, rst_n=0):
  - State is IDLE.
  - All outputs are 0: rom_en, rom_addr, sp_in_valid, sp_inst, busy, done, err, err_code, inst_count.
- States: IDLE, FETCH, LOAD, ISSUE, WAIT, DONE, ERR. All outputs are registered or decoded directly from the state.
- IDLE:
  - start=1 with num_inst=0: go to DONE, inst_count stays 0.
  - start=1 with num_inst>0: latch num_inst, clear inst_count/err/err_code, go to FETCH.
- FETCH:
  - sp_inst_addr[1:0]!=0: go to ERR with code 3.
  - sp_inst_addr[31:2] >= 2^ROM_AW: go to ERR with code 2.
  - Otherwise: rom_en=1, rom_addr=sp_inst_addr[ROM_AW+1:2], go to LOAD.
- LOAD: capture rom_rdata into the instruction register, go to ISSUE.
- ISSUE:
  - sp_in_valid=1 and sp_inst=instruction register for exactly one cycle.
  - Clear the latency counter.
  - sp_out_valid=1 in the same cycle counts as completion.
  - Otherwise go to WAIT.
- WAIT:
  - sp_out_valid=1: completion.
  - Otherwise increment the latency counter. When it reaches MAX_LAT, go to ERR with code 1.
- Completion:
  - inst_count+1.
  - If the new count equals the latched num_inst, go to DONE; else go to FETCH.
  - The next fetch uses the core's updated inst_addr, so branches and jumps are followed automatically.
- sp_inst is 0 whenever sp_in_valid=0. sp_out_valid outside ISSUE/WAIT is ignored.
- DONE: done=1 for one cycle, then IDLE. inst_count holds until the next start.
- ERR: err=1, stays in ERR until abort or start. start from ERR behaves as start from IDLE.
- abort has priority over all transitions, including start in the same cycle.
  - Next state is IDLE; sp_in_valid drops immediately.
  - inst_count and err are held.
- start while busy is ignored.
- Throughput: minimum 3 cycles per instruction (FETCH, LOAD, ISSUE with same-cycle out_valid); 4 cycles with the usual next-cycle out_valid.
- inst_count wraps modulo 2^CNT_W. It cannot exceed num_inst in practice.
- Reset mid-run: immediate return to IDLE with all outputs 0. There is no handshake with the core, which is reset by the same rst_n.

Test Plan:
- Reset: rst_n low 1 cycle mid-WAIT -> all outputs 0, state IDLE; start afterwards runs normally.
- Straight-line run: ROM holds 4 ADDI instructions, core answers out_valid 1 cycle after in_valid, num_inst=4 -> 4 in_valid pulses with rom_addr 0,1,2,3, each pulse 4 cycles apart; done pulse 16 cycles after start; inst_count=4.
- Branch follow: ROM[1]=BEQ taken to byte 0x20, num_inst=3 -> rom_addr sequence 0,1,8.
- Timeout: core never asserts out_valid -> err=1, err_code=1 exactly MAX_LAT=10 WAIT cycles after the ISSUE cycle; sp_in_valid=0 thereafter.
- Range/alignment errors:
  - PC 0x1000 with ROM_AW=10 -> err_code=2, no rom_en.
  - PC 0x0006 -> err_code=3.
- Edges:
  - num_inst=0 -> done next cycle, no rom_en.
  - abort and start in the same cycle during WAIT -> IDLE, no new run.
  - start during busy -> ignored, count unaffected.

Source files
------------

// File: rtl/sp_issue_ctrl.sv
// sp_issue_ctrl: instruction-issue sequencer for the single-cycle core (SP).
// Reads each instruction from a synchronous ROM at the core's current PC,
// hands it over with a one-cycle in_valid pulse, waits for out_valid under a
// latency limit, counts retirements and stops after num_inst of them.
module sp_issue_ctrl #(
  parameter int ROM_AW  = 10,  // ROM word-address width
  parameter int MAX_LAT = 10,  // WAIT cycles without out_valid before timeout
  parameter int CNT_W   = 16   // instruction counter width
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  num_inst,
  output logic              rom_en,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [31:0]       rom_rdata,
  output logic              sp_in_valid,
  output logic [31:0]       sp_inst,
  input  logic              sp_out_valid,
  input  logic [31:0]       sp_inst_addr,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [CNT_W-1:0]  inst_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_ISSUE,
    S_WAIT,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [1:0] ERR_NONE       = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT    = 2'd1;
  localparam logic [1:0] ERR_RANGE      = 2'd2;
  localparam logic [1:0] ERR_MISALIGNED = 2'd3;

  // The latency counter only ever holds 0 .. MAX_LAT-1.
  localparam int LAT_W = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  state_t            state;
  logic [31:0]       inst_q;     // instruction register, loaded in LOAD
  logic [LAT_W-1:0]  lat;        // WAIT cycles spent on the current instruction
  logic [CNT_W-1:0]  num_q;      // retirement target latched at start

  logic              pc_misaligned;
  logic              pc_out_of_range;
  logic              fetch_ok;
  logic              start_ok;
  logic              complete;
  logic [CNT_W-1:0]  count_inc;

  // PC checks: byte PC must be word aligned and inside the ROM word range.
  assign pc_misaligned   = |sp_inst_addr[1:0];
  assign pc_out_of_range = |sp_inst_addr[31:ROM_AW+2];

  // The ROM is synchronous, so the read must be issued during FETCH for the
  // data to be ready in LOAD; enable and address are therefore decoded from
  // the state and the core's PC rather than registered.
  // NOTE: outputs built with continuous assigns and a full ternary cannot
  // infer latches; every decoded value has a defined result in every state.
  assign fetch_ok    = (state == S_FETCH) && !pc_misaligned && !pc_out_of_range;
  assign rom_en      = fetch_ok;
  assign rom_addr    = fetch_ok ? sp_inst_addr[ROM_AW+1:2] : '0;

  assign sp_in_valid = (state == S_ISSUE);
  assign sp_inst     = sp_in_valid ? inst_q : 32'h0;
  assign busy        = (state == S_FETCH) || (state == S_LOAD) ||
                       (state == S_ISSUE) || (state == S_WAIT);
  assign done        = (state == S_DONE);

  // A run may begin from IDLE or from ERR; out_valid counts only while an
  // instruction is outstanding.
  assign start_ok  = start && ((state == S_IDLE) || (state == S_ERR));
  assign complete  = sp_out_valid && ((state == S_ISSUE) || (state == S_WAIT));
  assign count_inc = inst_count + 1'b1;

  // Sequencer: abort beats start, start beats completion, completion beats
  // the per-state progression.
  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      inst_q     <= '0;
      lat        <= '0;
      num_q      <= '0;
      inst_count <= '0;
      err        <= 1'b0;
      err_code   <= ERR_NONE;
    end else if (abort) begin
      state <= S_IDLE;
    end else if (start_ok) begin
      num_q      <= num_inst;
      inst_count <= '0;
      err        <= 1'b0;
      err_code   <= ERR_NONE;
      state      <= (num_inst == '0) ? S_DONE : S_FETCH;
    end else if (complete) begin
      inst_count <= count_inc;
      state      <= (count_inc == num_q) ? S_DONE : S_FETCH;
    end else begin
      case (state)
        S_FETCH: begin
          if (pc_misaligned) begin
            err      <= 1'b1;
            err_code <= ERR_MISALIGNED;
            state    <= S_ERR;
          end else if (pc_out_of_range) begin
            err      <= 1'b1;
            err_code <= ERR_RANGE;
            state    <= S_ERR;
          end else begin
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          inst_q <= rom_rdata;
          state  <= S_ISSUE;
        end
        S_ISSUE: begin
          lat   <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (lat == LAT_W'(MAX_LAT - 1)) begin
            err      <= 1'b1;
            err_code <= ERR_TIMEOUT;
            state    <= S_ERR;
          end else begin
            lat <= lat + 1'b1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= state;  // IDLE and ERR hold until start
      endcase
    end
  end

endmodule

// File: tb/tb_sp_issue_ctrl.sv
// Self-checking bench for sp_issue_ctrl. Contains a ROM, a small core model
// that answers in_valid after a programmable delay and follows branches, and
// a timeline model that predicts every output cycle by cycle from the run
// parameters (instruction count, core response delay, starting PC).
module tb_sp_issue_ctrl;
  localparam int ROM_AW  = 10;
  localparam int MAX_LAT = 10;
  localparam int CNT_W   = 16;
  localparam int MAXT    = 64;
  localparam int NEVER   = -1;

  typedef struct packed {
    logic        b;     // busy
    logic        en;    // rom_en
    logic [9:0]  addr;  // rom_addr
    logic        iv;    // sp_in_valid
    logic [31:0] inst;  // sp_inst
    logic        dn;    // done
    logic        er;    // err
    logic [1:0]  code;  // err_code
    logic [15:0] cnt;   // inst_count
  } obs_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              abort;
  logic [CNT_W-1:0]  num_inst;
  logic              rom_en;
  logic [ROM_AW-1:0] rom_addr;
  logic [31:0]       rom_rdata = 32'h0;
  logic              sp_in_valid;
  logic [31:0]       sp_inst;
  logic              sp_out_valid;
  logic [31:0]       sp_inst_addr;
  logic              busy;
  logic              done;
  logic              err;
  logic [1:0]        err_code;
  logic [CNT_W-1:0]  inst_count;

  always #5 clk = ~clk;

  sp_issue_ctrl #(.ROM_AW(ROM_AW), .MAX_LAT(MAX_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .num_inst(num_inst), .rom_en(rom_en), .rom_addr(rom_addr),
    .rom_rdata(rom_rdata), .sp_in_valid(sp_in_valid), .sp_inst(sp_inst),
    .sp_out_valid(sp_out_valid), .sp_inst_addr(sp_inst_addr), .busy(busy),
    .done(done), .err(err), .err_code(err_code), .inst_count(inst_count)
  );

  // ---------------- ROM and core model ----------------
  logic [31:0] rom [0:(1<<ROM_AW)-1];

  always @(posedge clk) if (rom_en) rom_rdata <= rom[rom_addr];

  // Core semantics: B-type opcode is always taken (BEQ x0,x0), else PC+4.
  function automatic logic [31:0] next_pc(input logic [31:0] pc, input logic [31:0] i);
    logic [31:0] imm;
    imm = {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
    return (i[6:0] == 7'h63) ? pc + imm : pc + 32'd4;
  endfunction

  logic [31:0] core_pc, held_inst, pc_reset_val, cur_inst;
  logic        waiting;
  int          wcnt;
  int          resp_delay;

  assign sp_inst_addr = core_pc;
  assign cur_inst     = sp_in_valid ? sp_inst : held_inst;
  always_comb sp_out_valid = (sp_in_valid && resp_delay == 0) ||
                             (waiting && wcnt == resp_delay);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_pc   <= pc_reset_val;
      waiting   <= 1'b0;
      wcnt      <= 0;
      held_inst <= 32'h0;
    end else if (sp_out_valid) begin
      core_pc <= next_pc(core_pc, cur_inst);
      waiting <= 1'b0;
    end else if (sp_in_valid) begin
      waiting   <= 1'b1;
      wcnt      <= 1;
      held_inst <= sp_inst;
    end else if (waiting) begin
      wcnt <= wcnt + 1;
    end
  end

  // ---------------- checking infrastructure ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic obs_t mk(input logic b, input logic en, input logic [9:0] addr,
                              input logic iv, input logic [31:0] inst, input logic dn,
                              input logic er, input logic [1:0] code, input logic [15:0] cnt);
    obs_t o;
    o.b = b; o.en = en; o.addr = addr; o.iv = iv; o.inst = inst;
    o.dn = dn; o.er = er; o.code = code; o.cnt = cnt;
    return o;
  endfunction

  function automatic obs_t sample();
    return mk(busy, rom_en, rom_addr, sp_in_valid, sp_inst, done, err, err_code, inst_count);
  endfunction

  // ---------------- timeline model ----------------
  // Offset 0 is the cycle right after the edge that samples start.
  // Each instruction occupies fetch, load, issue, then d response cycles.
  obs_t exp_tab [MAXT];
  int   m_done_at, m_err_at;

  task automatic plan_run(input int n, input int d, input logic [31:0] pc0, output int len);
    logic [31:0] pc, ins;
    logic [15:0] cnt;
    logic [1:0]  code;
    int          t;
    for (int i = 0; i < MAXT; i++) exp_tab[i] = '0;
    pc = pc0; t = 0; cnt = 16'd0; m_done_at = -1; m_err_at = -1;
    for (int k = 0; k < n; k++) begin
      if (pc[1:0] != 2'b00 || (pc >> 2) >= (32'd1 << ROM_AW)) begin
        code = (pc[1:0] != 2'b00) ? 2'd3 : 2'd2;
        exp_tab[t] = mk(1, 0, 0, 0, 0, 0, 0, 0, cnt);
        for (int i = t + 1; i < t + 4; i++) exp_tab[i] = mk(0, 0, 0, 0, 0, 0, 1, code, cnt);
        m_err_at = t + 1; len = t + 4;
        return;
      end
      ins = rom[pc[ROM_AW+1:2]];
      exp_tab[t]     = mk(1, 1, pc[ROM_AW+1:2], 0, 0, 0, 0, 0, cnt);
      exp_tab[t + 1] = mk(1, 0, 0, 0, 0, 0, 0, 0, cnt);
      exp_tab[t + 2] = mk(1, 0, 0, 1, ins, 0, 0, 0, cnt);
      if (d < 0) begin
        for (int i = t + 3; i < t + 3 + MAX_LAT; i++) exp_tab[i] = mk(1, 0, 0, 0, 0, 0, 0, 0, cnt);
        for (int i = t + 3 + MAX_LAT; i < t + 6 + MAX_LAT; i++)
          exp_tab[i] = mk(0, 0, 0, 0, 0, 0, 1, 2'd1, cnt);
        m_err_at = t + 3 + MAX_LAT; len = t + 6 + MAX_LAT;
        return;
      end
      for (int w = 1; w <= d; w++) exp_tab[t + 2 + w] = mk(1, 0, 0, 0, 0, 0, 0, 0, cnt);
      pc = next_pc(pc, ins); cnt++; t = t + 3 + d;
    end
    exp_tab[t] = mk(0, 0, 0, 0, 0, 1, 0, 0, cnt);
    for (int i = t + 1; i < t + 4; i++) exp_tab[i] = mk(0, 0, 0, 0, 0, 0, 0, 0, cnt);
    m_done_at = t; len = t + 4;
  endtask

  // ---------------- observation of DUT events ----------------
  int         o_done_at, o_err_at;
  logic [1:0] o_code;
  logic [9:0] o_fetch [$];

  function automatic int fetch_at(input int k);
    return (k < o_fetch.size()) ? int'(o_fetch[k]) : -1;
  endfunction

  // Start a run and compare every cycle against the model; entered and left
  // 2 time units after a rising edge. inj >= 0 pulses start (num_inst=7) at
  // that offset while the run is busy.
  task automatic run_window(input string tag, input int n, input int d,
                            input logic [31:0] pc0, input int limit, input int inj);
    int   len;
    obs_t s;
    plan_run(n, d, pc0, len);
    if (limit < len) len = limit;
    resp_delay = (d < 0) ? 1000 : d;
    start = 1'b1; num_inst = 16'(n);
    o_done_at = -1; o_err_at = -1; o_code = 2'd0; o_fetch.delete();
    for (int off = 0; off < len; off++) begin
      @(posedge clk); #2;
      s = sample();
      check($sformatf("%s_cyc%0d", tag, off), 96'(s), 96'(exp_tab[off]));
      if (s.en) o_fetch.push_back(s.addr);
      if (s.dn && o_done_at < 0) o_done_at = off;
      if (s.er && o_err_at < 0) begin o_err_at = off; o_code = s.code; end
      start = (off == inj);
      if (off == inj) num_inst = 16'd7;
    end
  endtask

  task automatic do_reset(input logic [31:0] pc0);
    pc_reset_val = pc0; start = 1'b0; abort = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    obs_t s;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; num_inst = '0;
    pc_reset_val = 32'h0; resp_delay = 1;
    for (int i = 0; i < (1 << ROM_AW); i++) rom[i] = 32'h0000_0013;
    rom[0] = 32'h0010_8093;  // addi x1,x1,1
    rom[1] = 32'h0021_0113;  // addi x2,x2,2
    rom[2] = 32'h0031_8193;  // addi x3,x3,3
    rom[3] = 32'h0042_0213;  // addi x4,x4,4

    #12;
    check("reset_outputs", 96'(sample()), 96'(0));
    @(posedge clk); #2; rst_n = 1'b1;

    // Straight line, 4 cycles per instruction, stray start at offset 5.
    run_window("straight", 4, 1, 32'h0, MAXT, 5);
    check("model_done_at_16", 96'(m_done_at), 96'(16));
    check("straight_done_at", 96'(o_done_at), 96'(16));
    check("straight_nfetch", 96'(o_fetch.size()), 96'(4));
    for (int k = 0; k < 4; k++)
      check($sformatf("straight_addr%0d", k), 96'(fetch_at(k)), 96'(k));
    check("straight_count", 96'(inst_count), 96'(4));

    // Same-cycle completion: 3 cycles per instruction.
    do_reset(32'h0);
    run_window("samecyc", 2, 0, 32'h0, MAXT, -1);
    check("model_done_at_6", 96'(m_done_at), 96'(6));
    check("samecyc_done_at", 96'(o_done_at), 96'(6));

    // Branch follow: beq x0,x0,+0x1C at byte 4 -> byte 0x20 (word 8).
    rom[1] = 32'h0000_0E63;
    rom[8] = 32'h0050_0293;
    do_reset(32'h0);
    run_window("branch", 3, 1, 32'h0, MAXT, -1);
    check("branch_addr0", 96'(fetch_at(0)), 96'(0));
    check("branch_addr1", 96'(fetch_at(1)), 96'(1));
    check("branch_addr2", 96'(fetch_at(2)), 96'(8));

    // Timeout: issue at offset 2, 10 WAIT cycles, err at offset 13.
    do_reset(32'h0);
    run_window("timeout", 2, NEVER, 32'h0, MAXT, -1);
    check("model_err_at_13", 96'(m_err_at), 96'(13));
    check("timeout_err_at", 96'(o_err_at), 96'(13));
    check("timeout_code", 96'(o_code), 96'(1));

    // Start from ERR behaves as from IDLE.
    run_window("from_err", 1, 1, 32'h0, MAXT, -1);
    check("from_err_done_at", 96'(o_done_at), 96'(4));

    // PC out of ROM range.
    do_reset(32'h0000_1000);
    run_window("range", 2, 1, 32'h0000_1000, MAXT, -1);
    check("range_code", 96'(o_code), 96'(2));
    check("range_no_rom_en", 96'(o_fetch.size()), 96'(0));

    // Misaligned PC.
    do_reset(32'h0000_0006);
    run_window("misalign", 2, 1, 32'h0000_0006, MAXT, -1);
    check("misalign_code", 96'(o_code), 96'(3));

    // num_inst = 0: done immediately, no fetch.
    do_reset(32'h0);
    run_window("zero", 0, 1, 32'h0, MAXT, -1);
    check("zero_done_at", 96'(o_done_at), 96'(0));
    check("zero_no_rom_en", 96'(o_fetch.size()), 96'(0));

    // abort + start together in WAIT of the second instruction (count = 1).
    rom[1] = 32'h0021_0113;
    do_reset(32'h0);
    run_window("abort_pre", 3, 2, 32'h0, 9, -1);
    abort = 1'b1; start = 1'b1; num_inst = 16'd3;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #2;
      abort = 1'b0; start = 1'b0;
      check($sformatf("abort_idle%0d", k), 96'(sample()), 96'(mk(0, 0, 0, 0, 0, 0, 0, 0, 16'd1)));
    end

    // Reset mid-WAIT (count = 1), then a normal run.
    do_reset(32'h0);
    run_window("rst_pre", 3, 2, 32'h0, 9, -1);
    rst_n = 1'b0;
    #1;
    s = sample();
    check("rst_async_zero", 96'(s), 96'(0));
    @(posedge clk); #2;
    check("rst_held_zero", 96'(sample()), 96'(0));
    rst_n = 1'b1;
    run_window("after_rst", 2, 1, 32'h0, MAXT, -1);
    check("after_rst_done_at", 96'(o_done_at), 96'(8));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
    $fatal(1, "watchdog");
  end

endmodule
